// File: rtl/linear_network_injector_seq_pkg.sv
// Shared types for the linear network injector: sequencing state and counter width default.
package linear_network_pkg;

    localparam int CNT_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        HOLD   = 2'b10
    } inj_state_e;

endpackage

// File: rtl/linear_network_injector_seq_if.sv
// Producer-side handshake and network-side drive signals of the injector.
interface linear_network_injector_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data_bus;
    logic [NUM_NODE-1:0]   i_dest;
    logic                  i_stall;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data_bus;
    logic [NUM_NODE-1:0]   o_cmd;
    logic                  o_en;

    modport master (
        output i_valid, i_data_bus, i_dest, i_stall,
        input  o_ready, o_valid, o_data_bus, o_cmd, o_en
    );

    modport slave (
        input  i_valid, i_data_bus, i_dest, i_stall,
        output o_ready, o_valid, o_data_bus, o_cmd, o_en
    );
endinterface

// File: rtl/linear_network_injector_seq_fifo.sv
// Synchronous circular FIFO with naturally wrapping pointers and an extra-bit occupancy count.
module sync_fifo_seq #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Overflow/underflow requests are ignored rather than corrupting the pointers.
    assign push_ok_s = push && (count_r != FULL_CNT);
    assign pop_ok_s  = pop && (count_r != {(AW+1){1'b0}});

    // Payload storage; no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {(AW+1){1'b0}});
    assign count = count_r;

endmodule

// File: rtl/linear_network_injector_seq.sv
// Buffered feeder for the linear multicast network: FIFO, output register, FSM and counters.
// Optional INJECTOR_ZERO_DEST_DROP_EN discards accepted packets whose destination mask is zero.
module linear_network_injector_seq
    import linear_network_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    linear_network_injector_seq_if.slave bus,
    output logic [CNT_WIDTH-1:0]         o_issue_cnt,
    output logic [CNT_WIDTH-1:0]         o_drop_cnt
);
    localparam int FW = DATA_WIDTH + NUM_NODE;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

    logic                  ready_en_r;
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [NUM_NODE-1:0]   cmd_r;
    logic [CNT_WIDTH-1:0]  issue_cnt_r;
    inj_state_e            state_r;
    inj_state_e            state_s;

    logic                  accept_s;
    logic                  push_s;
    logic                  load_s;
    logic                  pop_s;
    logic [FW-1:0]         fifo_rdata_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CW-1:0]         fifo_count_s;

    // Ready depends only on registers; ready_en_r keeps it low while reset is applied.
    assign bus.o_ready = ready_en_r && (fifo_count_s != FULL_CNT);
    assign accept_s    = bus.i_valid && bus.o_ready;
    assign load_s      = !bus.i_stall;
    assign pop_s       = load_s && !fifo_empty_s;
    assign bus.o_en    = ~bus.i_stall;

`ifdef INJECTOR_ZERO_DEST_DROP_EN
    assign push_s = accept_s && !fifo_full_s && (bus.i_dest != {NUM_NODE{1'b0}});
`else
    assign push_s = accept_s && !fifo_full_s;
`endif

    sync_fifo_seq #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata ({bus.i_data_bus, bus.i_dest}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Ready enable: low through reset, high from the first cycle after it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Output register: loads the FIFO head (or a bubble) whenever the network is not frozen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            cmd_r   <= {NUM_NODE{1'b0}};
        end else if (load_s) begin
            valid_r <= pop_s;
            data_r  <= pop_s ? fifo_rdata_s[FW-1:NUM_NODE] : {DATA_WIDTH{1'b0}};
            cmd_r   <= pop_s ? fifo_rdata_s[NUM_NODE-1:0] : {NUM_NODE{1'b0}};
        end
    end

    assign bus.o_valid    = valid_r;
    assign bus.o_data_bus = data_r;
    assign bus.o_cmd      = cmd_r;

    // Issue counter, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (pop_s) begin
            issue_cnt_r <= issue_cnt_r + CNT_ONE;
        end
    end

    assign o_issue_cnt = issue_cnt_r;

`ifdef INJECTOR_ZERO_DEST_DROP_EN
    logic [CNT_WIDTH-1:0] drop_cnt_r;

    // Drop counter: accepted packets with an empty destination mask.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (accept_s && (bus.i_dest == {NUM_NODE{1'b0}})) begin
            drop_cnt_r <= drop_cnt_r + CNT_ONE;
        end
    end

    assign o_drop_cnt = drop_cnt_r;
`else
    assign o_drop_cnt = {CNT_WIDTH{1'b0}};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; HOLD is only entered while a valid packet is frozen on the outputs.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (bus.i_stall) begin
                    if (valid_r) begin
                        state_s = HOLD;
                    end else begin
                        state_s = ACTIVE;
                    end
                end else if (fifo_empty_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ACTIVE;
                end
            end
            HOLD: begin
                if (!bus.i_stall) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_linear_network_injector_seq.sv
// Scoreboard bench for linear_network_injector_seq: directed stimulus, decoupled output monitor.
module tb_linear_network_injector_seq;
    localparam int DW = 32;
    localparam int NN = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] drop_cnt;

    int            tests = 0;
    int            fails = 0;
    logic [35:0]   exp_q[$];
    logic [35:0]   mon_exp;
    int            run_len = 0;
    int            max_run = 0;
    bit            ready_low_seen = 1'b0;

    always #5 clk = ~clk;

    linear_network_injector_seq_if #(.DATA_WIDTH(DW), .NUM_NODE(NN)) bus ();

    linear_network_injector_seq #(
        .DATA_WIDTH (DW),
        .NUM_NODE   (NN),
        .FIFO_DEPTH (4),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_issue_cnt (issue_cnt),
        .o_drop_cnt  (drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every packet the network takes (valid with enable) must match the queue head.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.o_valid === 1'b1 && bus.o_en === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: unexpected packet data 0x%0h cmd 0x%0h, expected none",
                         bus.o_data_bus, bus.o_cmd);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard", {28'h0, bus.o_data_bus, bus.o_cmd}, {28'h0, mon_exp});
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic push_pkt(input logic [31:0] d, input logic [3:0] m);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        bus.i_valid    = 1'b1;
        bus.i_data_bus = d;
        bus.i_dest     = m;
        while (!done) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) begin
                done = 1'b1;
`ifdef INJECTOR_ZERO_DEST_DROP_EN
                if (m != 4'b0000) exp_q.push_back({d, m});
`else
                exp_q.push_back({d, m});
`endif
            end else begin
                ready_low_seen = 1'b1;
                n++;
                if (n > 100) begin
                    tests++;
                    fails++;
                    $display("FAIL push_timeout: o_ready stayed 0 for %0d cycles, expected 1", n);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.i_valid    = 1'b0;
        bus.i_data_bus = 32'h0;
        bus.i_dest     = 4'h0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        bus.i_stall = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        bus.i_stall = 1'b0;
        idle();

        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", bus.o_ready, 1'b0);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_data", bus.o_data_bus, 32'h0);
        check("rst_cmd", bus.o_cmd, 4'h0);
        check("rst_issue", issue_cnt, 16'h0);
        check("rst_drop", drop_cnt, 16'h0);
        check("rst_en_unstalled", bus.o_en, 1'b1);
        @(posedge clk);
        #1;
        bus.i_stall = 1'b1;
        @(negedge clk);
        check("rst_en_stalled", bus.o_en, 1'b0);
        check("rst_ready_held", bus.o_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.i_stall = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_rst", bus.o_ready, 1'b1);

        // Single packet latency
        @(posedge clk);
        #1;
        push_pkt(32'hAAAA_AAAA, 4'b0001);
        idle();
        @(negedge clk);
        check("lat_cycle1_valid", bus.o_valid, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_cycle2_valid", bus.o_valid, 1'b1);
        check("lat_cycle2_cmd", bus.o_cmd, 4'b0001);
        check("lat_cycle2_data", bus.o_data_bus, 32'hAAAA_AAAA);
        check("lat_issue_cnt", issue_cnt, 16'd1);
        wait_cycles(3);

        // Back-to-back throughput
        do_reset();
        ready_low_seen = 1'b0;
        max_run = 0;
        for (int i = 1; i <= 8; i++) push_pkt(i, 4'(i));
        idle();
        wait_cycles(6);
        check("tput_ready_low", ready_low_seen, 1'b0);
        check("tput_run_len", max_run, 8);
        check("tput_issue_cnt", issue_cnt, 16'd8);

        // Stall with backpressure
        do_reset();
        push_pkt(32'h11, 4'b0001);
        push_pkt(32'h12, 4'b0010);
        bus.i_stall = 1'b1;
        push_pkt(32'h13, 4'b0100);
        push_pkt(32'h14, 4'b1000);
        push_pkt(32'h15, 4'b0011);
        bus.i_valid    = 1'b1;
        bus.i_data_bus = 32'h16;
        bus.i_dest     = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_ready_full", bus.o_ready, 1'b0);
            check("stall_en", bus.o_en, 1'b0);
            check("stall_valid_held", bus.o_valid, 1'b1);
            check("stall_data_held", bus.o_data_bus, 32'h11);
            @(posedge clk);
            #1;
        end
        bus.i_stall = 1'b0;
        push_pkt(32'h16, 4'b0110);
        idle();
        wait_cycles(10);
        check("stall_issue_cnt", issue_cnt, 16'd6);
        check("stall_drained", exp_q.size(), 0);

        // Zero destination mask
        do_reset();
        push_pkt(32'hDEAD_BEEF, 4'b0000);
        push_pkt(32'h5, 4'b0010);
        idle();
        wait_cycles(6);
`ifdef INJECTOR_ZERO_DEST_DROP_EN
        check("zero_dest_drop_cnt", drop_cnt, 16'd1);
        check("zero_dest_issue_cnt", issue_cnt, 16'd1);
`else
        check("zero_dest_drop_cnt", drop_cnt, 16'd0);
        check("zero_dest_issue_cnt", issue_cnt, 16'd2);
`endif

        // Reset mid-operation
        do_reset();
        push_pkt(32'h20, 4'b0001);
        push_pkt(32'h21, 4'b0010);
        bus.i_stall = 1'b1;
        push_pkt(32'h22, 4'b0100);
        push_pkt(32'h23, 4'b1000);
        idle();
        @(negedge clk);
        check("midrst_pre_valid", bus.o_valid, 1'b1);
        check("midrst_pre_issue", issue_cnt, 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_valid", bus.o_valid, 1'b0);
        check("midrst_data", bus.o_data_bus, 32'h0);
        check("midrst_cmd", bus.o_cmd, 4'h0);
        check("midrst_issue", issue_cnt, 16'h0);
        check("midrst_ready", bus.o_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.i_stall = 1'b0;
        wait_cycles(8);
        check("midrst_no_stale", issue_cnt, 16'h0);

        // Issue counter wrap
        do_reset();
        for (int i = 0; i < 65535; i++) push_pkt(i, 4'b1000);
        idle();
        wait_cycles(5);
        check("wrap_full_count", issue_cnt, 16'hFFFF);
        push_pkt(32'hCAFE, 4'b0001);
        idle();
        wait_cycles(5);
        check("wrap_to_zero", issue_cnt, 16'h0000);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
